// File: rtl/pwm_from_count.sv
// Registered PWM generator driven by an upstream free-running counter.
// Duty changes go through a load/busy/ack shadow and take effect only on a period boundary.
module pwm_from_count #(
  parameter int CNT_W    = 4,
  parameter int PCNT_W   = 8,
  parameter int DUTY_RST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              enable,
  input  logic [CNT_W-1:0]  duty_in,
  input  logic              duty_load,
  output logic              duty_busy,
  output logic              duty_ack,
  output logic              duty_err,
  output logic [CNT_W-1:0]  duty_active,
  output logic              pwm_out,
  output logic              period_start,
  output logic [PCNT_W-1:0] period_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   prev_count_q;
  logic               pwm_q, pwm_d;
  logic [CNT_W-1:0]   duty_active_q, duty_active_d;
  logic [CNT_W-1:0]   shadow_q, shadow_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic [PCNT_W-1:0]  pcount_q, pcount_d;

  logic               wrap;
  logic               run_cmp;
  logic               apply_shadow;
  logic [CNT_W-1:0]   duty_eff;

  // A wrap is only the all-ones -> zero step; any other discontinuity is ignored.
  assign wrap         = (count_in == '0) && (prev_count_q == '1);
  assign run_cmp      = (state_q == RUN) || ((state_q == SYNC) && wrap && enable);
  assign apply_shadow = (state_q == RUN) && wrap && busy_q;
  assign duty_eff     = apply_shadow ? shadow_q : duty_active_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = SYNC;
      SYNC: begin
        if (!enable)   state_d = IDLE;
        else if (wrap) state_d = RUN;
      end
      RUN:     if (wrap && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pwm_d         = 1'b0;
    duty_active_d = duty_active_q;
    shadow_d      = shadow_q;
    busy_d        = busy_q;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    start_d       = 1'b0;
    pcount_d      = pcount_q;

    if (run_cmp) begin
      pwm_d = (count_in < duty_eff);
    end

    if (state_q != RUN) begin
      // A shadow still pending outside RUN (load on the final wrap) is applied here, never dropped.
      if (busy_q) begin
        duty_active_d = shadow_q;
        busy_d        = 1'b0;
        ack_d         = 1'b1;
        err_d         = duty_load;
      end else if (duty_load) begin
        duty_active_d = duty_in;
        ack_d         = 1'b1;
      end
    end else begin
      if (apply_shadow) begin
        duty_active_d = shadow_q;
        busy_d        = 1'b0;
        ack_d         = 1'b1;
      end
      // Busy is judged on the registered flag, so a load in the cycle busy clears is still rejected.
      if (duty_load) begin
        if (busy_q) begin
          err_d = 1'b1;
        end else begin
          shadow_d = duty_in;
          busy_d   = 1'b1;
        end
      end
    end

    if (wrap && run_cmp) begin
      start_d  = 1'b1;
      pcount_d = pcount_q + PCNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_count_q  <= '0;
      pwm_q         <= 1'b0;
      duty_active_q <= CNT_W'(DUTY_RST);
      shadow_q      <= '0;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      start_q       <= 1'b0;
      pcount_q      <= '0;
    end else begin
      state_q       <= state_d;
      prev_count_q  <= count_in;
      pwm_q         <= pwm_d;
      duty_active_q <= duty_active_d;
      shadow_q      <= shadow_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      start_q       <= start_d;
      pcount_q      <= pcount_d;
    end
  end

  assign duty_busy    = busy_q;
  assign duty_ack     = ack_q;
  assign duty_err     = err_q;
  assign duty_active  = duty_active_q;
  assign pwm_out      = pwm_q;
  assign period_start = start_q;
  assign period_count = pcount_q;

endmodule
